// File: rtl/inst_prefetch_if.sv
// inst_prefetch_if
//   Bundles the three buses around the instruction prefetch stage:
//   the instruction memory request/response pair, the instruction
//   valid/ready stream toward the core, and the redirect input from the core.
// Ports (signals)
//   imem_req     prefetch -> memory  one-cycle read request pulse
//   imem_addr    prefetch -> memory  request address (PC_W)
//   imem_rvalid  memory -> prefetch  response strobe
//   imem_rdata   memory -> prefetch  instruction word (32)
//   inst_valid   prefetch -> core    FIFO head valid
//   inst_ready   core -> prefetch    head consumed when valid & ready
//   inst         prefetch -> core    head instruction word (32)
//   inst_pc      prefetch -> core    head instruction address (PC_W)
//   redirect     core -> prefetch    flush and restart fetch
//   redirect_pc  core -> prefetch    new fetch address (PC_W)
// Modports: master = prefetch stage, slave = its environment (memory + core).
interface inst_prefetch_if #(
  parameter int PC_W = 6
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_prefetch.sv
// inst_prefetch
//   Fetch stage in front of the RV32I accumulator core. Walks the program
//   pointer, keeps at most one instruction-memory read outstanding, and
//   buffers returned words together with their PC in a small FIFO whose
//   head is presented to the core. A redirect from the core flushes the
//   FIFO and any in-flight read, and restarts fetch at redirect_pc.
// Ports
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      inst_prefetch_if.master (memory, core stream, redirect)
module inst_prefetch #(
  parameter int PC_W     = 6,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0,
  parameter int DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  inst_prefetch_if.master   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] RESET_PC_C = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] STEP_C     = PC_W'(PC_STEP);
  localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, READY, WAIT, DISCARD} state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] fetch_pc, req_pc;
  logic [31:0]     mem_data [DEPTH];
  logic [PC_W-1:0] mem_pc   [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]   count, count_left, count_next;
  logic [31:0]     inst_q, head_data_next;
  logic [PC_W-1:0] inst_pc_q, head_pc_next;
  logic            issue, push, pop;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state plus the issue/push strobes. An issue is only allowed while
  // a FIFO slot is free, so the single in-flight word always has room.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE:    state_next = READY;
      READY: begin
        if (!bus.redirect && (count < DEPTH_C)) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          push       = !bus.redirect;
          state_next = READY;
        end else if (bus.redirect) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.imem_rvalid) state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop = (count != '0) && bus.inst_ready;

  // Next head of the FIFO. When the queue drains to empty in the same cycle
  // a word arrives, the arriving word becomes the head directly.
  always_comb begin
    rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_left = count - CW'(pop);
    count_next = count_left + CW'(push);
    if (count_left == '0) begin
      head_data_next = bus.imem_rdata;
      head_pc_next   = req_pc;
    end else begin
      head_data_next = mem_data[rd_next];
      head_pc_next   = mem_pc[rd_next];
    end
  end

  // Program pointer and the address of the outstanding request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC_C;
      req_pc   <= '0;
    end else begin
      if (bus.redirect)  fetch_pc <= bus.redirect_pc;
      else if (issue)    fetch_pc <= fetch_pc + STEP_C;
      if (issue)         req_pc   <= fetch_pc;
    end
  end

  // FIFO storage; needs no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= bus.imem_rdata;
      mem_pc[wr_ptr]   <= req_pc;
    end
  end

  // FIFO pointers, occupancy and registered head. A redirect empties the
  // queue; the head registers keep their last value whenever it is empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) begin
        inst_q    <= head_data_next;
        inst_pc_q <= head_pc_next;
      end
    end
  end

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch
//   Directed bench for inst_prefetch. A queue-based model of the fetch
//   stage predicts every output each cycle; a one-request memory answers
//   with address-tagged words after a programmable latency. Directed
//   scenarios add hand-computed literal expectations.
// Ports: none (top-level bench).
module tb_inst_prefetch;
  localparam int PC_W  = 6;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  inst_prefetch_if #(.PC_W(PC_W)) bus ();

  inst_prefetch #(
    .PC_W(PC_W), .PC_STEP(2), .RESET_PC(0), .DEPTH(DEPTH)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory responder
  int              memLat;
  bit              memPending;
  logic [PC_W-1:0] memAddr;
  int              memDue;
  logic [7:0]      memSerial;

  // model
  logic [PC_W-1:0] mFetch, mReqPc, mLastPc;
  logic [31:0]     mLastData;
  bit              mStarted, mInFlight, mDrop;
  logic [PC_W-1:0] qPc[$];
  logic [31:0]     qData[$];

  // logs
  logic [PC_W-1:0] reqLog[$];
  logic [PC_W-1:0] popPcLog[$];
  logic [31:0]     popDataLog[$];
  int              firstValidCyc;
  int              releaseCyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] logAt(input logic [PC_W-1:0] q[$], input int i);
    if (i < q.size()) return 32'(q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic applyStimulus(input bit rdy, input bit redir, input logic [PC_W-1:0] rpc);
    bus.inst_ready  = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    if (memPending && memDue == cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = {8'hA5, memSerial, 10'b0, memAddr};
      memPending      = 1'b0;
      memSerial++;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic checkOutput();
    bit              expReq, expValid;
    logic [PC_W-1:0] expPc;
    logic [31:0]     expData;
    expReq   = mStarted && !mInFlight && !bus.redirect && (qPc.size() < DEPTH);
    expValid = (qPc.size() != 0);
    if (expValid) begin
      expPc   = qPc[0];
      expData = qData[0];
    end else begin
      expPc   = mLastPc;
      expData = mLastData;
    end
    check("imem_req", 32'(bus.imem_req), 32'(expReq));
    if (expReq) check("imem_addr", 32'(bus.imem_addr), 32'(mFetch));
    check("inst_valid", 32'(bus.inst_valid), 32'(expValid));
    check("inst_pc", 32'(bus.inst_pc), 32'(expPc));
    check("inst", bus.inst, expData);
    if (bus.imem_req === 1'b1) begin
      reqLog.push_back(bus.imem_addr);
      memPending = 1'b1;
      memAddr    = bus.imem_addr;
      memDue     = cyc + memLat;
    end
    if (bus.inst_valid === 1'b1 && bus.inst_ready && !bus.redirect) begin
      popPcLog.push_back(bus.inst_pc);
      popDataLog.push_back(bus.inst);
    end
    if (bus.inst_valid === 1'b1 && firstValidCyc < 0) firstValidCyc = cyc;
  endtask

  task automatic updateModel();
    bit issue, pop;
    issue = mStarted && !mInFlight && !bus.redirect && (qPc.size() < DEPTH);
    pop   = (qPc.size() != 0) && bus.inst_ready;
    if (qPc.size() != 0) begin
      mLastPc   = qPc[0];
      mLastData = qData[0];
    end
    if (bus.redirect) begin
      qPc.delete();
      qData.delete();
      mFetch = bus.redirect_pc;
      if (mInFlight) begin
        if (bus.imem_rvalid) begin
          mInFlight = 1'b0;
          mDrop     = 1'b0;
        end else begin
          mDrop = 1'b1;
        end
      end
    end else begin
      if (pop) begin
        void'(qPc.pop_front());
        void'(qData.pop_front());
      end
      if (mInFlight && bus.imem_rvalid) begin
        if (!mDrop) begin
          qPc.push_back(mReqPc);
          qData.push_back(bus.imem_rdata);
        end
        mInFlight = 1'b0;
        mDrop     = 1'b0;
      end
      if (issue) begin
        mInFlight = 1'b1;
        mReqPc    = mFetch;
        mFetch    = mFetch + 6'd2;
      end
    end
    mStarted = 1'b1;
  endtask

  task automatic stepCycle(input bit rdy, input bit redir, input logic [PC_W-1:0] rpc);
    @(negedge clock);
    applyStimulus(rdy, redir, rpc);
    #1;
    checkOutput();
    updateModel();
    cyc++;
  endtask

  task automatic runCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) stepCycle(rdy, 1'b0, '0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic doReset(input int lat);
    #1 reset_n = 1'b0;
    #1;
    check("reset imem_req", 32'(bus.imem_req), 32'h0);
    check("reset imem_addr", 32'(bus.imem_addr), 32'h0);
    check("reset inst_valid", 32'(bus.inst_valid), 32'h0);
    check("reset inst", bus.inst, 32'h0);
    check("reset inst_pc", 32'(bus.inst_pc), 32'h0);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    memPending = 1'b0;
    memSerial  = '0;
    memLat     = lat;
    mFetch = '0; mReqPc = '0; mLastPc = '0; mLastData = '0;
    mStarted = 1'b0; mInFlight = 1'b0; mDrop = 1'b0;
    qPc.delete(); qData.delete();
    reqLog.delete(); popPcLog.delete(); popDataLog.delete();
    firstValidCyc = -1;
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    releaseCyc = cyc;
  endtask

  logic [PC_W-1:0] seq4[4] = '{6'd0, 6'd2, 6'd4, 6'd6};

  initial begin
    reset_n = 1'b1;

    // 1: back-to-back fetch with a one-cycle memory
    doReset(1);
    runCycles(12, 1'b1);
    check("t1 first valid latency", 32'(firstValidCyc - releaseCyc), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("t1 req addr", logAt(reqLog, i), 32'(seq4[i]));
      check("t1 pop pc", logAt(popPcLog, i), 32'(seq4[i]));
      if (i < popDataLog.size())
        check("t1 pop data tag", 32'(popDataLog[i][PC_W-1:0]), 32'(seq4[i]));
    end

    // 2: core stalled, FIFO fills, then one pop frees one slot
    doReset(1);
    runCycles(14, 1'b0);
    check("t2 req count full", 32'(reqLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("t2 req addr", logAt(reqLog, i), 32'(seq4[i]));
    check("t2 head pc", 32'(bus.inst_pc), 32'd0);
    stepCycle(1'b1, 1'b0, '0);
    runCycles(4, 1'b0);
    check("t2 req count after pop", 32'(reqLog.size()), 32'd5);
    check("t2 refill addr", logAt(reqLog, 4), 32'd8);
    check("t2 popped pc", logAt(popPcLog, 0), 32'd0);

    // 3: redirect while waiting on a slow response
    doReset(3);
    runCycles(2, 1'b0);
    stepCycle(1'b0, 1'b1, 6'h20);
    runCycles(2, 1'b0);
    stepCycle(1'b0, 1'b0, '0);
    check("t3 fifo empty", 32'(bus.inst_valid), 32'd0);
    check("t3 req after redirect", 32'(bus.imem_req), 32'd1);
    check("t3 addr after redirect", 32'(bus.imem_addr), 32'h20);
    runCycles(8, 1'b0);
    check("t3 second req", logAt(reqLog, 1), 32'h20);
    check("t3 head valid", 32'(bus.inst_valid), 32'd1);
    check("t3 head pc", 32'(bus.inst_pc), 32'h20);

    // 4: redirect together with rvalid and a pop
    doReset(1);
    runCycles(4, 1'b0);
    stepCycle(1'b1, 1'b1, 6'h30);
    check("t4 no req in redirect cycle", 32'(bus.imem_req), 32'd0);
    stepCycle(1'b0, 1'b0, '0);
    check("t4 flushed", 32'(bus.inst_valid), 32'd0);
    check("t4 req next cycle", 32'(bus.imem_req), 32'd1);
    check("t4 req addr", 32'(bus.imem_addr), 32'h30);
    runCycles(4, 1'b0);

    // 5: pointer wrap from 62 to 0
    doReset(1);
    runCycles(1, 1'b1);
    stepCycle(1'b1, 1'b1, 6'd62);
    runCycles(8, 1'b1);
    check("t5 req 62", logAt(reqLog, 0), 32'd62);
    check("t5 req wrap", logAt(reqLog, 1), 32'd0);
    check("t5 pop 62", logAt(popPcLog, 0), 32'd62);
    check("t5 pop wrap", logAt(popPcLog, 1), 32'd0);

    // 6: async reset mid-WAIT with three buffered words
    doReset(3);
    runCycles(15, 1'b0);
    check("t6 pre-reset valid", 32'(bus.inst_valid), 32'd1);
    doReset(1);
    runCycles(4, 1'b1);
    check("t6 restart addr", logAt(reqLog, 0), 32'd0);
    check("t6 restart count", 32'(reqLog.size()), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
